// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronised and deglitched keyboard clock, 11-bit frame
// checker (start, 8 data LSB-first, odd parity, stop) and a byte FIFO with sticky errors.
module ps2_kbd_rx #(
  parameter int DEPTH   = 8,
  parameter int FILT    = 4,
  parameter int TIMEOUT = 50000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ps2_clk,
  input  logic                   ps2_data,
  input  logic                   pop,
  input  logic                   err_clr,
  output logic [7:0]             data,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic                   parity_err,
  output logic                   frame_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = (FILT > 1) ? $clog2(FILT) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]   FULL_LVL  = (AW + 1)'(DEPTH);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILT - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  logic [1:0]    clk_sync_q, clk_sync_d;
  logic [1:0]    dat_sync_q, dat_sync_d;
  logic          clk_s2_s, dat_s2_s;
  logic          filt_clk_q, filt_clk_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic          strobe_s;

  state_t        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          push_s, par_bad_s, stop_bad_s, tmo_abort_s;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          full_s, do_push_s, do_pop_s, ovf_set_s;

  logic          overflow_q, overflow_d;
  logic          parity_err_q, parity_err_d;
  logic          frame_err_q, frame_err_d;

  always_comb begin
    clk_sync_d = {clk_sync_q[0], ps2_clk};
    dat_sync_d = {dat_sync_q[0], ps2_data};
    clk_s2_s   = clk_sync_q[1];
    dat_s2_s   = dat_sync_q[1];
  end

  // The filtered clock flips on the FILT-th consecutive disagreeing sample;
  // the strobe fires in the cycle whose edge takes it from 1 to 0.
  always_comb begin
    filt_clk_d = filt_clk_q;
    filt_cnt_d = '0;
    if (clk_s2_s != filt_clk_q) begin
      if (filt_cnt_q == FILT_LAST) begin
        filt_clk_d = ~filt_clk_q;
        filt_cnt_d = '0;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end else begin
      filt_cnt_d = '0;
    end
    strobe_s = filt_clk_q & ~filt_clk_d;
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    tmo_cnt_d   = tmo_cnt_q;
    push_s      = 1'b0;
    par_bad_s   = 1'b0;
    stop_bad_s  = 1'b0;
    tmo_abort_s = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (strobe_s && !dat_s2_s) begin
          state_d   = ST_DATA;
          bit_cnt_d = 3'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (strobe_s) begin
          shift_d = {dat_s2_s, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            state_d   = ST_PARITY;
            bit_cnt_d = 3'd0;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (strobe_s) begin
          parity_d = dat_s2_s;
          state_d  = ST_STOP;
        end else begin
          state_d = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (strobe_s) begin
          state_d    = ST_IDLE;
          par_bad_s  = ~(^{shift_q, parity_q});
          stop_bad_s = ~dat_s2_s;
          push_s     = dat_s2_s & (^{shift_q, parity_q});
        end else begin
          state_d = ST_STOP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Any stall longer than TIMEOUT inside a frame abandons it.
    if (strobe_s) begin
      tmo_cnt_d = '0;
    end else if (state_q == ST_IDLE) begin
      tmo_cnt_d = '0;
    end else if (tmo_cnt_q == TMO_LAST) begin
      tmo_cnt_d   = '0;
      state_d     = ST_IDLE;
      tmo_abort_s = 1'b1;
    end else begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
  end

  // A pop in the same cycle frees the slot a full-FIFO push needs.
  always_comb begin
    do_pop_s  = pop & (level_q != '0);
    full_s    = (level_q == FULL_LVL);
    do_push_s = push_s & (~full_s | do_pop_s);
    ovf_set_s = push_s & full_s & ~do_pop_s;

    wr_ptr_d = do_push_s ? (wr_ptr_q + 1'b1) : wr_ptr_q;
    rd_ptr_d = do_pop_s  ? (rd_ptr_q + 1'b1) : rd_ptr_q;

    case ({do_push_s, do_pop_s})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    overflow_d   = (overflow_q   & ~err_clr) | ovf_set_s;
    parity_err_d = (parity_err_q & ~err_clr) | par_bad_s;
    frame_err_d  = (frame_err_q  & ~err_clr) | stop_bad_s | tmo_abort_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_q   <= 2'b11;
      dat_sync_q   <= 2'b11;
      filt_clk_q   <= 1'b1;
      filt_cnt_q   <= '0;
      state_q      <= ST_IDLE;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      parity_q     <= 1'b0;
      tmo_cnt_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      overflow_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      clk_sync_q   <= clk_sync_d;
      dat_sync_q   <= dat_sync_d;
      filt_clk_q   <= filt_clk_d;
      filt_cnt_q   <= filt_cnt_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      parity_q     <= parity_d;
      tmo_cnt_q    <= tmo_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      overflow_q   <= overflow_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= shift_q;
    end
  end

  assign data       = mem_q[rd_ptr_q];
  assign valid      = (level_q != '0);
  assign level      = level_q;
  assign overflow   = overflow_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;

endmodule

// File: doc/ps2_kbd_rx.md
PS2_KBD_RX -- requirements
Module: ps2_kbd_rx

Interface
REQ-001 Parameter DEPTH, default 8: FIFO entries; power of two, >=2.
REQ-002 Parameter FILT, default 4: consecutive clk samples required to accept a ps2_clk level change.
REQ-003 Parameter TIMEOUT, default 50000: clk cycles without a falling edge after which a partial frame is aborted.
REQ-004 clk  input  1  system clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 ps2_clk  input  1  keyboard clock, asynchronous to clk.
REQ-007 ps2_data  input  1  keyboard data, asynchronous to clk.
REQ-008 pop  input  1  consume head byte; honoured only when valid=1.
REQ-009 err_clr  input  1  clear all sticky error flags.
REQ-010 data  output  8  FIFO head byte; don't-care when valid=0.
REQ-011 valid  output  1  FIFO non-empty.
REQ-012 level  output  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.
REQ-013 overflow  output  1  sticky: good byte dropped because FIFO full.
REQ-014 parity_err  output  1  sticky: frame with bad odd parity discarded.
REQ-015 frame_err  output  1  sticky: bad stop bit or timeout abort.

Function
REQ-016 ps2_clk and ps2_data SHALL pass through 2-flop synchronisers.
REQ-017 Filtered ps2_clk SHALL change only after FILT consecutive synchronised samples differ from its current value.
REQ-018 Sample strobe SHALL be a one-cycle pulse on each filtered 1->0 transition; ps2_data sampled from its synchroniser on that cycle.
REQ-019 Receive FSM states: IDLE, DATA, PARITY, STOP.
REQ-020 IDLE: strobe with data=0 -> DATA, bit counter 0; strobe with data=1 ignored, no error.
REQ-021 DATA: shift in 8 bits LSB-first; after 8th strobe -> PARITY.
REQ-022 PARITY: capture parity bit on strobe -> STOP.
REQ-023 STOP: on strobe -> IDLE; push byte only if stop=1 and data+parity has odd number of ones.
REQ-024 Bad parity: discard, set parity_err; stop=0: discard, set frame_err; both conditions set both flags.
REQ-025 Timeout counter SHALL clear on every strobe, count only outside IDLE; on reaching TIMEOUT -> IDLE, discard partial frame, set frame_err.
REQ-026 Push SHALL write on the edge where the STOP strobe is sampled; valid/level/data reflect it from that edge (no extra latency).
REQ-027 pop with valid=1 SHALL advance read pointer and decrement level on that edge; pop with valid=0 ignored.
REQ-028 Push while full without pop: byte dropped, contents unchanged, overflow set.
REQ-029 Push and pop same cycle while full: both performed, level unchanged, overflow not set.
REQ-030 Push and pop same cycle while empty: push performed, pop ignored, level becomes 1.
REQ-031 Read/write pointers SHALL wrap modulo DEPTH.
REQ-032 err_clr SHALL clear overflow, parity_err, frame_err; a setting event in the same cycle wins.

Reset
REQ-033 rst=1 SHALL immediately, independent of clk: FSM IDLE; pointers, level, valid, timeout and bit counters 0; all sticky flags 0; synchronisers and filtered clock 1.
REQ-034 rst asserted mid-frame SHALL discard the partial frame and empty the FIFO; after release the receiver waits for a new start bit.
REQ-035 FIFO storage array is not reset.

Verification
REQ-036 Frame 0x1C, parity 0, stop 1 -> valid=1, data=0x1C, level=1; pop -> valid=0, level=0.
REQ-037 Frame 0xF0 with parity 0 (correct is 1) -> level stays 0, parity_err=1; err_clr -> parity_err=0.
REQ-038 DEPTH=8, frames 0x01..0x09 without pop -> level=8, overflow=1; 8 pops return 0x01..0x08 in order.
REQ-039 Start bit plus 3 data bits, then idle TIMEOUT cycles, then frame 0x5A -> frame_err=1, level=1, data=0x5A.
REQ-040 ps2_clk low glitch of FILT-1 clk cycles mid-frame -> no bit sampled, following frame received correctly.
REQ-041 FIFO full (8), pop asserted on the STOP-strobe cycle of a good frame -> level=8, overflow=0, newest byte last out.
